audio_sfx_scheduler: RTL and testbench
======================================

Name: audio_sfx_scheduler

Overview:
Avalon-MM slave that owns the 2-bit audio codec control lines and schedules sound-effect playback requests into the audio datapath. Four requesters raise sound-effect requests: player shot, enemy shot, explosion and bonus. Requests can come from game logic hardware pulses or from NIOS software triggers. The block latches them as pending, arbitrates one at a time, and hands the winning effect ID to the audio player over a valid/ready handshake. It then enforces a play timeout and a minimum inter-effect gap.

Parameters:
TIMER_W, 24, width of play/gap timer.
MAX_PLAY_CYCLES, 5000000, timeout for one effect if play_done never arrives (100 ms at 50 MHz).
GAP_CYCLES, 16, minimum idle cycles between end of one effect and next offer; must be >= 1.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  Avalon register select
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data; combinational, zero wait states
sfx_req  in  4  hardware request lines, same clock domain, rising edge = request
play_valid  out  1  effect offer to audio player
play_id  out  2  effect index, valid while play_valid
play_ready  in  1  audio player accepts offer
play_done  in  1  one-cycle pulse, effect finished
codec_ctrl  out  2  codec control lines, direct from CTRL[1:0]
irq  out  1  level, high while STATUS.drop_cnt != 0 and CTRL.irq_en

Behaviour:
- Reset values: all registers 0; play_valid=0, play_id=0, codec_ctrl=0, irq=0; FSM=IDLE; rr pointer=0; sfx_req edge-detect history=0.
- Write = chipselect & ~write_n. Unmapped bits read 0.
- Register map:
  - addr0 CTRL R/W: [1:0] codec_ctrl, [2] enable, [3] arb_mode (0 fixed, 1 round-robin), [4] irq_en.
  - addr1 PENDING R: [3:0] pending. Write-1-to-clear.
  - addr2 SW_TRIG W: bits [3:0] set pending. Reads 0.
  - addr3 STATUS R: [0] busy (FSM!=IDLE), [3:2] current play_id, [15:8] drop_cnt. Any write clears drop_cnt.
- Request latch:
  - Set source per bit = rising edge of sfx_req[i] (registered history) OR SW_TRIG write bit i.
  - Set on a bit already pending: pending stays 1, drop_cnt += 1, saturates at 255. Only one increment per cycle regardless of bit count.
  - Set and W1C on the same bit, same cycle: set wins.
  - Pending latches even when enable=0.
- FSM IDLE -> OFFER -> PLAYING -> GAP -> IDLE.
  - IDLE: if enable and pending!=0, grant one bit. Clear that pending bit, load play_id, set play_valid next cycle, go OFFER. A grant clear and a new set on the same bit in the same cycle leaves the bit set (counts as new request, no drop).
  - Fixed mode: lowest index wins.
  - Round-robin mode: search starts at rr pointer. After a grant, pointer = granted+1 mod 4.
  - OFFER: play_valid=1, play_id stable. play_valid is never retracted, even if enable drops. When play_valid & play_ready: play_valid=0 next cycle, timer loads MAX_PLAY_CYCLES-1, go PLAYING.
  - PLAYING: timer decrements each cycle. Go GAP on play_done, or on timer==0 with play_done absent (timeout). play_done seen in IDLE/OFFER/GAP is ignored.
  - GAP: timer loads GAP_CYCLES-1 on entry and decrements. At 0 go IDLE.
  - Minimum cycles from play_done to next play_valid rise = GAP_CYCLES+1.
- enable=0 in IDLE holds IDLE. In OFFER/PLAYING/GAP the current effect completes normally, then the FSM stays in IDLE.
- codec_ctrl updates the cycle after the CTRL write, independent of FSM.
- Reset asserted mid-operation: all state returns to reset values immediately; play_valid drops asynchronously.

Test Plan:
- Reset, then write CTRL=0x3 -> codec_ctrl=2'b11 one cycle later; readback CTRL=0x3; play_valid stays 0 (enable=0).
- CTRL=0x4, pulse sfx_req[2] -> PENDING=0x4; next cycle grant clears it; play_valid=1, play_id=2 until play_ready; play_done then GAP_CYCLES idle; STATUS.busy=0 after.
- Fixed mode, SW_TRIG=0xF while busy -> play_ids issued in order 0,1,2,3. Round-robin with last grant 1 and SW_TRIG=0xB -> order 3,0,1.
- Pulse sfx_req[0] three times while pending[0]=1 -> drop_cnt=3, irq=1 with irq_en; write STATUS -> drop_cnt=0, irq=0. 300 drops -> drop_cnt=255.
- Accept offer, never assert play_done -> FSM leaves PLAYING exactly MAX_PLAY_CYCLES cycles after acceptance (bench MAX_PLAY_CYCLES=100).
- W1C PENDING bit 1 in the same cycle as an sfx_req[1] rising edge -> pending[1]=1. Assert reset_n=0 during OFFER -> play_valid=0 immediately, all registers 0.

Source files
------------

// File: rtl/audio_sfx_scheduler.sv
// audio_sfx_scheduler
// Avalon-MM slave that owns the audio codec control lines and schedules
// sound-effect playback. Requests from hardware pulses (sfx_req rising
// edges) or software triggers are latched as pending. One request is
// arbitrated at a time and offered to the audio player over a valid/ready
// handshake. A play timeout and a minimum inter-effect gap are enforced.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata   Avalon-MM write side
//   readdata             Avalon-MM read data, combinational, zero wait
//   sfx_req[3:0]         hardware request lines, rising edge = request
//   play_valid, play_id  effect offer to the audio player
//   play_ready           player accepts the offer
//   play_done            one-cycle pulse when the effect has finished
//   codec_ctrl[1:0]      codec control lines, mirror of CTRL[1:0]
//   irq                  high while drop_cnt != 0 and CTRL.irq_en
//
// Register map:
//   0 CTRL    R/W [1:0] codec_ctrl, [2] enable, [3] arb_mode, [4] irq_en
//   1 PENDING R   [3:0] pending, write-1-to-clear
//   2 SW_TRIG W   [3:0] set pending, reads 0
//   3 STATUS  R   [0] busy, [3:2] play_id, [15:8] drop_cnt; write clears drop_cnt
module audio_sfx_scheduler #(
    parameter int TIMER_W         = 24,
    parameter int MAX_PLAY_CYCLES = 5000000,
    parameter int GAP_CYCLES      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [3:0]  sfx_req,
    output logic        play_valid,
    output logic [1:0]  play_id,
    input  logic        play_ready,
    input  logic        play_done,
    output logic [1:0]  codec_ctrl,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OFFER   = 2'd1,
        ST_PLAYING = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0] PLAY_LOAD  = TIMER_W'(MAX_PLAY_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    // First pending index found when scanning upward (mod 4) from start.
    function automatic logic [1:0] pick_grant(input logic [3:0] pend,
                                              input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = start;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx   = start + 2'(k);
            res   = (!found && pend[idx]) ? idx : res;
            found = found | pend[idx];
        end
        return res;
    endfunction

    state_t              state_r, state_nx;
    logic [TIMER_W-1:0]  timer_r, timer_nx;
    logic [4:0]          ctrl_r, ctrl_nx;
    logic [3:0]          pending_r, pending_nx;
    logic [7:0]          drop_cnt_r, drop_cnt_nx;
    logic [3:0]          req_hist_r;
    logic [1:0]          rr_ptr_r, rr_ptr_nx;
    logic [1:0]          play_id_r, play_id_nx;
    logic                play_valid_r;
    logic                irq_r, irq_nx;

    logic                wr_en_s, ctrl_wr_s, pend_wr_s, trig_wr_s, stat_wr_s;
    logic [3:0]          set_s, w1c_s, grant_mask_s;
    logic [1:0]          grant_idx_s;
    logic                drop_s;
    logic                unused_s;

    assign wr_en_s   = chipselect & ~write_n;
    assign ctrl_wr_s = wr_en_s & (address == 2'd0);
    assign pend_wr_s = wr_en_s & (address == 2'd1);
    assign trig_wr_s = wr_en_s & (address == 2'd2);
    assign stat_wr_s = wr_en_s & (address == 2'd3);
    assign unused_s  = ^writedata[31:5];

    // Arbitration and playback state machine: next state, timer, grant.
    always_comb begin
        state_nx     = state_r;
        timer_nx     = timer_r;
        play_id_nx   = play_id_r;
        rr_ptr_nx    = rr_ptr_r;
        grant_mask_s = 4'b0000;
        grant_idx_s  = pick_grant(pending_r, ctrl_r[3] ? rr_ptr_r : 2'd0);
        case (state_r)
            ST_IDLE: begin
                if (ctrl_r[2] && (pending_r != 4'b0000)) begin
                    state_nx     = ST_OFFER;
                    play_id_nx   = grant_idx_s;
                    grant_mask_s = 4'b0001 << grant_idx_s;
                    rr_ptr_nx    = grant_idx_s + 2'd1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_OFFER: begin
                // play_valid is always high here, so ready alone completes it
                if (play_ready) begin
                    state_nx = ST_PLAYING;
                    timer_nx = PLAY_LOAD;
                end else begin
                    state_nx = ST_OFFER;
                end
            end
            ST_PLAYING: begin
                if (play_done || (timer_r == TIMER_ZERO)) begin
                    state_nx = ST_GAP;
                    timer_nx = GAP_LOAD;
                end else begin
                    timer_nx = timer_r - TIMER_ONE;
                end
            end
            ST_GAP: begin
                if (timer_r == TIMER_ZERO) begin
                    state_nx = ST_IDLE;
                end else begin
                    timer_nx = timer_r - TIMER_ONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Request latch, drop counter, CTRL and irq next values.
    always_comb begin
        set_s      = (sfx_req & ~req_hist_r) | (trig_wr_s ? writedata[3:0] : 4'b0000);
        w1c_s      = pend_wr_s ? writedata[3:0] : 4'b0000;
        // set wins over both software clear and grant clear
        pending_nx = (pending_r & ~(w1c_s | grant_mask_s)) | set_s;
        // a set landing on a bit being granted this cycle is a new request
        drop_s     = |(set_s & pending_r & ~grant_mask_s);
        if (stat_wr_s) begin
            drop_cnt_nx = 8'h00;
        end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_nx = drop_cnt_r + 8'h01;
        end else begin
            drop_cnt_nx = drop_cnt_r;
        end
        ctrl_nx = ctrl_wr_s ? writedata[4:0] : ctrl_r;
        irq_nx  = (drop_cnt_nx != 8'h00) & ctrl_nx[4];
    end

    // State and register update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            timer_r      <= TIMER_ZERO;
            ctrl_r       <= 5'b00000;
            pending_r    <= 4'b0000;
            drop_cnt_r   <= 8'h00;
            req_hist_r   <= 4'b0000;
            rr_ptr_r     <= 2'd0;
            play_id_r    <= 2'd0;
            play_valid_r <= 1'b0;
            irq_r        <= 1'b0;
        end else begin
            state_r      <= state_nx;
            timer_r      <= timer_nx;
            ctrl_r       <= ctrl_nx;
            pending_r    <= pending_nx;
            drop_cnt_r   <= drop_cnt_nx;
            req_hist_r   <= sfx_req;
            rr_ptr_r     <= rr_ptr_nx;
            play_id_r    <= play_id_nx;
            play_valid_r <= (state_nx == ST_OFFER);
            irq_r        <= irq_nx;
        end
    end

    // Register read mux.
    always_comb begin
        case (address)
            2'd0:    readdata = {27'd0, ctrl_r};
            2'd1:    readdata = {28'd0, pending_r};
            2'd2:    readdata = 32'd0;
            2'd3:    readdata = {16'd0, drop_cnt_r, 4'd0, play_id_r, 1'b0,
                                 (state_r != ST_IDLE)};
            default: readdata = 32'd0;
        endcase
    end

    assign play_valid = play_valid_r;
    assign play_id    = play_id_r;
    assign codec_ctrl = ctrl_r[1:0];
    assign irq        = irq_r;

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// Directed self-checking bench for audio_sfx_scheduler.
module tb_audio_sfx_scheduler;

    localparam int MAXP = 100;
    localparam int GAP  = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [3:0]  sfx_req = 4'd0;
    logic        play_valid;
    logic [1:0]  play_id;
    logic        play_ready = 1'b0;
    logic        play_done = 1'b0;
    logic [1:0]  codec_ctrl;
    logic        irq;

    int total = 0;
    int bad   = 0;

    audio_sfx_scheduler #(
        .TIMER_W(24), .MAX_PLAY_CYCLES(MAXP), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .sfx_req(sfx_req), .play_valid(play_valid), .play_id(play_id),
        .play_ready(play_ready), .play_done(play_done),
        .codec_ctrl(codec_ctrl), .irq(irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (play_valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, play_valid}, 32'd1);
    endtask

    task automatic play_one(input string tag, output logic [1:0] id);
        wait_valid(tag);
        id = play_id;
        play_ready = 1'b1;
        tick();
        play_ready = 1'b0;
        play_done = 1'b1;
        tick();
        play_done = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  id;
        int          n;

        // reset state
        #1;
        chk("rst play_valid", {31'd0, play_valid}, 32'd0);
        chk("rst codec", {30'd0, codec_ctrl}, 32'd0);
        chk("rst irq", {31'd0, irq}, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            chk("rst readback", d, 32'd0);
        end

        // codec control follows CTRL one cycle after the write
        wr(2'd0, 32'h3);
        chk("codec after write", {30'd0, codec_ctrl}, 32'd3);
        rd(2'd0, d);
        chk("ctrl readback", d, 32'h3);
        tick(); tick();
        chk("no offer when disabled", {31'd0, play_valid}, 32'd0);

        // single hardware request on bit 2
        wr(2'd0, 32'h4);
        sfx_req = 4'b0100;
        tick();
        sfx_req = 4'b0000;
        rd(2'd1, d);
        chk("pending after req2", d, 32'h4);
        tick();
        rd(2'd1, d);
        chk("pending cleared by grant", d, 32'h0);
        chk("offer valid", {31'd0, play_valid}, 32'd1);
        chk("offer id", {30'd0, play_id}, 32'd2);
        rd(2'd3, d);
        chk("status in offer", d, 32'h9);
        tick(); tick(); tick();
        chk("offer held", {31'd0, play_valid}, 32'd1);
        chk("offer id held", {30'd0, play_id}, 32'd2);
        play_ready = 1'b1;
        tick();
        play_ready = 1'b0;
        chk("valid drops after accept", {31'd0, play_valid}, 32'd0);
        rd(2'd3, d);
        chk("busy while playing", {31'd0, d[0]}, 32'd1);
        play_done = 1'b1;
        tick();
        play_done = 1'b0;
        n = 0;
        d = 32'd1;
        while (d[0] !== 1'b0 && n < 50) begin
            tick();
            n++;
            rd(2'd3, d);
        end
        chk("gap length", n, GAP);
        chk("busy clear", {31'd0, d[0]}, 32'd0);

        // fixed priority: all four pending
        wr(2'd0, 32'h0);
        wr(2'd2, 32'hF);
        rd(2'd1, d);
        chk("sw trig pending", d, 32'hF);
        wr(2'd0, 32'h4);
        for (int k = 0; k < 4; k++) begin
            play_one("fixed offer", id);
            chk("fixed order", {30'd0, id}, k);
        end

        // round-robin: last grant 1, then 0xB -> 3,0,1
        wr(2'd0, 32'hC);
        wr(2'd2, 32'h2);
        play_one("rr first offer", id);
        chk("rr first id", {30'd0, id}, 32'd1);
        wr(2'd0, 32'h8);
        wr(2'd2, 32'hB);
        wr(2'd0, 32'hC);
        play_one("rr offer a", id);
        chk("rr order a", {30'd0, id}, 32'd3);
        play_one("rr offer b", id);
        chk("rr order b", {30'd0, id}, 32'd0);
        play_one("rr offer c", id);
        chk("rr order c", {30'd0, id}, 32'd1);

        // drop counting and irq
        wr(2'd0, 32'h10);
        wr(2'd2, 32'h1);
        for (int k = 0; k < 3; k++) begin
            sfx_req = 4'b0001;
            tick();
            sfx_req = 4'b0000;
            tick();
        end
        rd(2'd3, d);
        chk("drop cnt 3", {24'd0, d[15:8]}, 32'd3);
        chk("irq set", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'h0);
        rd(2'd3, d);
        chk("drop cnt cleared", {24'd0, d[15:8]}, 32'd0);
        chk("irq cleared", {31'd0, irq}, 32'd0);
        for (int k = 0; k < 300; k++) begin
            wr(2'd2, 32'h1);
        end
        rd(2'd3, d);
        chk("drop cnt saturates", {24'd0, d[15:8]}, 32'd255);
        chk("irq at saturation", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'h0);
        wr(2'd2, 32'hF);
        wr(2'd2, 32'hF);
        rd(2'd3, d);
        chk("one drop per cycle", {24'd0, d[15:8]}, 32'd2);
        wr(2'd1, 32'hF);
        rd(2'd1, d);
        chk("w1c all", d, 32'h0);
        wr(2'd3, 32'h0);

        // timeout: no play_done
        wr(2'd0, 32'h4);
        wr(2'd2, 32'h1);
        wait_valid("timeout offer");
        play_ready = 1'b1;
        tick();
        play_ready = 1'b0;
        n = 0;
        d = 32'd1;
        while (d[0] !== 1'b0 && n < 300) begin
            tick();
            n++;
            rd(2'd3, d);
        end
        chk("timeout plus gap", n, MAXP + GAP);

        // W1C and rising edge on the same bit: set wins
        wr(2'd0, 32'h0);
        wr(2'd2, 32'h2);
        sfx_req = 4'b0010;
        wr(2'd1, 32'h2);
        sfx_req = 4'b0000;
        rd(2'd1, d);
        chk("set beats w1c", d, 32'h2);
        wr(2'd1, 32'h2);
        rd(2'd1, d);
        chk("w1c alone", d, 32'h0);

        // asynchronous reset during an offer
        wr(2'd0, 32'h7);
        wr(2'd2, 32'h4);
        tick();
        chk("offer before reset", {31'd0, play_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("valid drops on reset", {31'd0, play_valid}, 32'd0);
        chk("codec on reset", {30'd0, codec_ctrl}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            chk("regs on reset", d, 32'd0);
        end
        tick();
        reset_n = 1'b1;
        tick(); tick();
        chk("idle after reset", {31'd0, play_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
